// File: rtl/icache_if.sv
// Fetch/memory bus of the instruction cache.
// The cache is the slave side; the fetcher and memory controller together form the master side.
// With ICACHE_STATS_EN defined the bus also carries the hit/miss counters.
interface icache_if;
    logic        in_fetcher_ena;
    logic [31:0] in_fetcher_addr;
    logic        out_fetcher_ok;
    logic [31:0] out_fetcher_inst;
    logic        out_mem_ena;
    logic [31:0] out_mem_addr;
    logic        in_mem_ok;
    logic [31:0] in_mem_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] out_hit_cnt;
    logic [31:0] out_miss_cnt;
`endif

    modport slave (
        input  in_fetcher_ena,
        input  in_fetcher_addr,
        output out_fetcher_ok,
        output out_fetcher_inst,
        output out_mem_ena,
        output out_mem_addr,
        input  in_mem_ok,
        input  in_mem_data
`ifdef ICACHE_STATS_EN
        ,
        output out_hit_cnt,
        output out_miss_cnt
`endif
    );

    modport master (
        output in_fetcher_ena,
        output in_fetcher_addr,
        input  out_fetcher_ok,
        input  out_fetcher_inst,
        input  out_mem_ena,
        input  out_mem_addr,
        output in_mem_ok,
        output in_mem_data
`ifdef ICACHE_STATS_EN
        ,
        input  out_hit_cnt,
        input  out_miss_cnt
`endif
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Hits answer one cycle after the request; misses issue a single read to the memory controller
// and answer one cycle after its completion. Rollback cancels any outstanding answer.
// Optional feature: define ICACHE_STATS_EN to add hit/miss counters on the bus.
module icache #(
    parameter int unsigned INDEX_BITS = 8
) (
    input logic       clk,
    input logic       rst,
    input logic       ena,
    input logic       in_rollback,
    icache_if.slave   bus
);
    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic {StIdle, StMiss} state_t;

    state_t                  state_q;
    logic [LINES-1:0]        valid_q;
    logic [31:0]             data_mem [LINES];
    logic [TAG_BITS-1:0]     tag_mem  [LINES];
    logic [INDEX_BITS-1:0]   miss_idx_q;
    logic [TAG_BITS-1:0]     miss_tag_q;
    logic                    ok_q;
    logic [31:0]             inst_q;
    logic                    mem_ena_q;
    logic [31:0]             mem_addr_q;

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_BITS-1:0]     req_tag;
    logic                    req_hit;
    logic                    accept;
    logic                    fill;

    // Decode the incoming request and classify it against the tag array.
    always_comb begin
        req_idx = bus.in_fetcher_addr[INDEX_BITS+1:2];
        req_tag = bus.in_fetcher_addr[31:INDEX_BITS+2];
        req_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
        accept  = (state_q == StIdle) && ena && bus.in_fetcher_ena && !in_rollback;
        // Memory completion is honoured even with ena low or under rollback.
        fill    = (state_q == StMiss) && bus.in_mem_ok;
    end

    // Control FSM with registered outputs; rollback overrides both acceptance and answer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            ok_q       <= 1'b0;
            inst_q     <= '0;
            mem_ena_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            ok_q      <= 1'b0;
            mem_ena_q <= 1'b0;
            if (fill) begin
                valid_q[miss_idx_q] <= 1'b1;
                state_q             <= StIdle;
                if (!in_rollback) begin
                    ok_q   <= 1'b1;
                    inst_q <= bus.in_mem_data;
                end
            end
            if (in_rollback) begin
                state_q <= StIdle;
            end else if (accept) begin
                if (req_hit) begin
                    ok_q   <= 1'b1;
                    inst_q <= data_mem[req_idx];
                end else begin
                    mem_ena_q  <= 1'b1;
                    mem_addr_q <= bus.in_fetcher_addr & 32'hFFFF_FFFC;
                    miss_idx_q <= req_idx;
                    miss_tag_q <= req_tag;
                    state_q    <= StMiss;
                end
            end
        end
    end

    // Line storage is not reset; valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_mem[miss_idx_q] <= bus.in_mem_data;
            tag_mem[miss_idx_q]  <= miss_tag_q;
        end
    end

    assign bus.out_fetcher_ok   = ok_q;
    assign bus.out_fetcher_inst = inst_q;
    assign bus.out_mem_ena      = mem_ena_q;
    assign bus.out_mem_addr     = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Count accepted requests; wraps naturally and ignores later rollbacks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept) begin
            if (req_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else         miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign bus.out_hit_cnt  = hit_cnt_q;
    assign bus.out_miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a table of fetches plus hand-written rollback/reset sequences.
// A memory model answers reads after a fixed latency; expected instructions and memory addresses
// are queued when requests are driven and compared when the cache produces them.
module tb_icache;
    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic in_rollback;

    icache_if bus();

    icache #(.INDEX_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .in_rollback (in_rollback),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          hit;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          errors = 0;
    int          tick_no = 0;
    int          ok_seen = 0;
    int          last_ok_tick = 0;
    int          hits_acc = 0;
    int          misses_acc = 0;
    logic [31:0] inst_exp_q [$];
    logic [31:0] mema_exp_q [$];
    int          mem_lat = 6;
    int          mem_cnt = 0;
    bit          mem_busy = 1'b0;
    logic [31:0] mem_req_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0050_0093;
        return (a ^ 32'h5A5A_0000) + 32'd7;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // One clock: sample #1 after the edge, run the memory model and the scoreboard.
    task automatic tick();
        logic [31:0] exp;
        @(posedge clk);
        #1;
        tick_no++;
        if (bus.in_mem_ok) bus.in_mem_ok = 1'b0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.in_mem_ok   = 1'b1;
                bus.in_mem_data = mem_word(mem_req_addr);
                mem_busy        = 1'b0;
            end
        end
        if (bus.out_fetcher_ok) begin
            if (inst_exp_q.size() == 0) begin
                check("unexpected_ok", 32'(bus.out_fetcher_ok), 32'd0);
            end else begin
                exp = inst_exp_q.pop_front();
                check("inst", bus.out_fetcher_inst, exp);
            end
            ok_seen++;
            last_ok_tick = tick_no;
        end
        if (bus.out_mem_ena) begin
            if (mema_exp_q.size() == 0) begin
                check("unexpected_mem_ena", 32'(bus.out_mem_ena), 32'd0);
            end else begin
                exp = mema_exp_q.pop_front();
                check("mem_addr", bus.out_mem_addr, exp);
            end
            mem_busy     = 1'b1;
            mem_cnt      = mem_lat;
            mem_req_addr = bus.out_mem_addr;
        end
    endtask

    // Issue one fetch; when an answer is expected, wait for it and check its latency.
    task automatic fetch(input logic [31:0] addr, input bit exp_hit, input bit expect_ok);
        int base;
        int t0;
        logic [31:0] line;
        line = addr & 32'hFFFF_FFFC;
        bus.in_fetcher_ena  = 1'b1;
        bus.in_fetcher_addr = addr;
        if (expect_ok) inst_exp_q.push_back(mem_word(line));
        if (!exp_hit) mema_exp_q.push_back(line);
        if (exp_hit) hits_acc++;
        else misses_acc++;
        base = ok_seen;
        tick();
        t0 = tick_no;
        bus.in_fetcher_ena = 1'b0;
        if (expect_ok) begin
            for (int i = 0; i < 40 && ok_seen == base; i++) tick();
            if (ok_seen == base) fail_now("ok_wait");
            else check("latency", 32'(last_ok_tick - t0), exp_hit ? 32'd0 : 32'(mem_lat + 1));
        end
    endtask

    task automatic wait_mem_idle();
        int n;
        n = 0;
        while ((mem_busy || bus.in_mem_ok) && n < 30) begin
            tick();
            n++;
        end
        if (mem_busy || bus.in_mem_ok) fail_now("mem_idle_wait");
    endtask

    initial begin
        int base;
        int n;

        vecs[0] = '{32'h0000_1000, 1'b0};
        vecs[1] = '{32'h0000_1000, 1'b1};
        vecs[2] = '{32'h0000_1002, 1'b1};
        vecs[3] = '{32'h0000_1400, 1'b0};
        vecs[4] = '{32'h0000_1000, 1'b0};
        vecs[5] = '{32'h0000_1004, 1'b0};
        vecs[6] = '{32'h0000_1007, 1'b1};
        vecs[7] = '{32'h0000_1001, 1'b1};

        rst                 = 1'b1;
        ena                 = 1'b1;
        in_rollback         = 1'b0;
        bus.in_fetcher_ena  = 1'b0;
        bus.in_fetcher_addr = '0;
        bus.in_mem_ok       = 1'b0;
        bus.in_mem_data     = '0;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset: everything quiet and zero.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_ok", 32'(bus.out_fetcher_ok), 32'd0);
            check("rst_inst", bus.out_fetcher_inst, 32'd0);
            check("rst_mem_ena", 32'(bus.out_mem_ena), 32'd0);
            check("rst_mem_addr", bus.out_mem_addr, 32'd0);
        end

        // Table: cold miss, hits, same-index conflict, neighbouring line.
        foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].hit, 1'b1);

        // Back-to-back hits, one per cycle.
        base = ok_seen;
        bus.in_fetcher_ena = 1'b1;
        bus.in_fetcher_addr = 32'h0000_1000; inst_exp_q.push_back(mem_word(32'h1000)); tick();
        bus.in_fetcher_addr = 32'h0000_1004; inst_exp_q.push_back(mem_word(32'h1004)); tick();
        bus.in_fetcher_addr = 32'h0000_1000; inst_exp_q.push_back(mem_word(32'h1000)); tick();
        bus.in_fetcher_ena = 1'b0;
        hits_acc += 3;
        check("b2b_count", 32'(ok_seen - base), 32'd3);

        // ena low: request is not accepted, held address stays.
        base = ok_seen;
        ena = 1'b0;
        bus.in_fetcher_ena  = 1'b1;
        bus.in_fetcher_addr = 32'h0000_1000;
        tick();
        tick();
        bus.in_fetcher_ena = 1'b0;
        ena = 1'b1;
        tick();
        check("ena_low_no_ok", 32'(ok_seen - base), 32'd0);
        check("ena_low_addr_held", bus.out_mem_addr, 32'h0000_1004);

        // Miss on 0x2000, rollback two cycles later; late return must be ignored.
        base = ok_seen;
        fetch(32'h0000_2000, 1'b0, 1'b0);
        tick();
        in_rollback = 1'b1;
        tick();
        in_rollback = 1'b0;
        wait_mem_idle();
        tick();
        check("rollback_no_ok", 32'(ok_seen - base), 32'd0);
        fetch(32'h0000_3000, 1'b0, 1'b1);

        // Rollback coincident with completion: line still filled, no answer.
        base = ok_seen;
        fetch(32'h0000_4000, 1'b0, 1'b0);
        n = 0;
        while (!bus.in_mem_ok && n < 30) begin
            tick();
            n++;
        end
        if (!bus.in_mem_ok) fail_now("mem_ok_wait");
        in_rollback = 1'b1;
        tick();
        in_rollback = 1'b0;
        tick();
        check("rollback_fill_no_ok", 32'(ok_seen - base), 32'd0);
        fetch(32'h0000_4000, 1'b1, 1'b1);

`ifdef ICACHE_STATS_EN
        check("hit_cnt", bus.out_hit_cnt, 32'(hits_acc));
        check("miss_cnt", bus.out_miss_cnt, 32'(misses_acc));
`endif

        // Reset during a miss: pending fill dropped, all lines invalid afterwards.
        fetch(32'h0000_5000, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_mem_addr", bus.out_mem_addr, 32'd0);
        mem_busy = 1'b0;
        bus.in_mem_ok = 1'b0;
        tick();
        rst = 1'b0;
        hits_acc = 0;
        misses_acc = 0;
        tick();
        fetch(32'h0000_1000, 1'b0, 1'b1);
        fetch(32'h0000_1000, 1'b1, 1'b1);
`ifdef ICACHE_STATS_EN
        check("hit_cnt_after_rst", bus.out_hit_cnt, 32'(hits_acc));
        check("miss_cnt_after_rst", bus.out_miss_cnt, 32'(misses_acc));
`endif

        tick();
        tick();
        check("inst_queue_empty", 32'(inst_exp_q.size()), 32'd0);
        check("mem_queue_empty", 32'(mema_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
